// File: rtl/keccak_byte_packer_if.sv
// keccak_byte_packer_if: byte-stream input and keccak word-side signals of the packer.
interface keccak_byte_packer_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        k_reset;
    logic [31:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [1:0]  k_byte_num;
    logic        k_buffer_full;
    logic        k_out_ready;

    modport master (
        input  s_data, s_valid, s_last, k_buffer_full, k_out_ready,
        output s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num
    );

    modport slave (
        output s_data, s_valid, s_last, k_buffer_full, k_out_ready,
        input  s_ready, k_reset, k_in, k_in_ready, k_is_last, k_byte_num
    );
endinterface

// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer: packs a byte stream big-endian into 32-bit words for the keccak core.
// Optional saturating words_sent counter enabled by KECCAK_PACKER_WORD_CNT_EN.
module keccak_byte_packer #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    keccak_byte_packer_if.master bus,
`ifdef KECCAK_PACKER_WORD_CNT_EN
    output logic [CNT_W-1:0]     words_sent,
`endif
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, CLEAR, PACK, EMIT, PAD, WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  pos_q, pos_d;
    logic [1:0]  bnum_q, bnum_d;
    logic [31:0] word_q, word_d;
    logic        last_q, last_d;
    logic        pad_q, pad_d;
    logic        take;
    logic        xfer;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    assign take = (state_q == PACK) && bus.s_valid;
    assign xfer = (state_q == EMIT || state_q == PAD) && !bus.k_buffer_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pos_q   <= 2'd0;
            bnum_q  <= 2'd0;
            word_q  <= 32'd0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            bnum_q  <= bnum_d;
            word_q  <= word_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        bnum_d  = bnum_q;
        word_d  = word_q;
        last_d  = last_q;
        pad_d   = pad_q;
        case (state_q)
            IDLE:  state_d = bus.s_valid ? CLEAR : IDLE;
            CLEAR: begin
                state_d = PACK;
                pos_d   = 2'd0;
                bnum_d  = 2'd0;
                word_d  = 32'd0;
                last_d  = 1'b0;
                pad_d   = 1'b0;
            end
            PACK: if (take) begin
                // Unwritten low bytes stay zero because the word is cleared before each fill.
                word_d = word_q | ({bus.s_data, 24'd0} >> {pos_q, 3'b000});
                pos_d  = pos_q + 2'd1;
                if (bus.s_last || pos_q == 2'd3) begin
                    state_d = EMIT;
                    last_d  = bus.s_last && pos_q != 2'd3;
                    pad_d   = bus.s_last && pos_q == 2'd3;
                    bnum_d  = last_d ? pos_q + 2'd1 : 2'd0;
                end
            end
            EMIT: if (xfer) begin
                state_d = last_q ? WAIT : pad_q ? PAD : PACK;
                pos_d   = 2'd0;
                word_d  = 32'd0;
            end
            PAD:   state_d = xfer ? WAIT : PAD;
            WAIT:  state_d = bus.k_out_ready ? IDLE : WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_ready    = state_q == PACK;
        bus.k_reset    = state_q == CLEAR;
        bus.k_in_ready = xfer;
        bus.k_in       = state_q == EMIT ? word_q : 32'd0;
        bus.k_is_last  = state_q == PAD || (state_q == EMIT && last_q);
        bus.k_byte_num = state_q == EMIT ? bnum_q : 2'd0;
        busy           = state_q != IDLE;
    end

`ifdef KECCAK_PACKER_WORD_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = state_q == CLEAR ? '0 :
                (xfer && cnt_q != '1) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign words_sent = cnt_q;
`endif
endmodule

// File: tb/tb_keccak_byte_packer.sv
// tb_keccak_byte_packer: scoreboard bench; expected words come from a byte-level packing model.
module tb_keccak_byte_packer;
    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] w;
        logic        l;
        logic [1:0]  b;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    keccak_byte_packer_if bus();
`ifdef KECCAK_PACKER_WORD_CNT_EN
    logic [15:0] words_sent;
`endif

    keccak_byte_packer #(.CNT_W(16)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
`ifdef KECCAK_PACKER_WORD_CNT_EN
        .words_sent(words_sent),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   resets_seen = 0;
    int   exp_words = 0;
    bit   in_wait = 0;
    bit   rand_bf = 0;
    bit   force_bf = 0;
    exp_t sb[$];
    exp_t e;

    initial begin
        bus.k_buffer_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.k_buffer_full = rand_bf ? ($urandom_range(0, 9) < 3) : force_bf;
        end
    end

    // Monitor: every k_in transfer is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) in_wait = 0;
        else begin
            if (bus.k_in_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected got=%h last=%0b bn=%0d", bus.k_in, bus.k_is_last, bus.k_byte_num);
                end else begin
                    e = sb.pop_front();
                    if ({bus.k_in, bus.k_is_last, bus.k_byte_num} !== {e.w, e.l, e.b}) begin
                        errors++;
                        $display("FAIL word got=%h/%0b/%0d exp=%h/%0b/%0d", bus.k_in, bus.k_is_last, bus.k_byte_num, e.w, e.l, e.b);
                    end
                    if (e.l) in_wait = 1;
                end
            end
            if (bus.k_reset) begin
                resets_seen++;
                checks++;
                if (in_wait || bus.k_in_ready) begin
                    errors++;
                    $display("FAIL k_reset_early in_wait=%0b k_in_ready=%0b", in_wait, bus.k_in_ready);
                end
            end
            if (bus.s_ready) begin
                checks++;
                if (in_wait || bus.k_in_ready) begin
                    errors++;
                    $display("FAIL s_ready_during_wait_or_emit got=1 exp=0");
                end
            end
            if (bus.k_out_ready && in_wait) in_wait = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic byte_q_t str_q(input string s);
        byte_q_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: bytes grouped four at a time, first byte most significant.
    task automatic push_expect(input byte_q_t m);
        int   n = m.size();
        int   nw = (n + 3) / 4;
        exp_t x;
        for (int w = 0; w < nw; w++) begin
            x.w = 32'd0;
            for (int k = 0; k < 4; k++)
                if (4 * w + k < n) x.w[31 - 8 * k -: 8] = m[4 * w + k];
            x.l = (w == nw - 1) && (n % 4 != 0);
            x.b = x.l ? 2'(n % 4) : 2'd0;
            sb.push_back(x);
        end
        if (n % 4 == 0) sb.push_back('{w: 32'd0, l: 1'b1, b: 2'd0});
        exp_words = nw + (n % 4 == 0 ? 1 : 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int t = 0;
        bus.s_data  = b;
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        do begin
            @(negedge clk);
            t++;
        end while (!bus.s_ready && t < 300);
        if (!bus.s_ready) begin
            errors++;
            $display("FAIL s_ready_timeout got=0 exp=1");
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t m);
        for (int i = 0; i < m.size(); i++) send_byte(m[i], i == m.size() - 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_msg();
        repeat (3) begin
            @(negedge clk);
            check("wait_busy_no_ready", {busy, bus.s_ready, bus.k_in_ready}, 64'b100);
        end
        @(posedge clk);
        #1;
        bus.k_out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.k_out_ready = 1'b0;
        @(negedge clk);
        check("idle_after_out_ready", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_msg(input byte_q_t m);
        int r0 = resets_seen;
        push_expect(m);
        send_msg(m);
        wait_drain();
        release_msg();
        check("one_k_reset_per_msg", resets_seen, r0 + 1);
`ifdef KECCAK_PACKER_WORD_CNT_EN
        check("words_sent", words_sent, exp_words);
`endif
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {bus.s_ready, bus.k_reset, bus.k_in, bus.k_in_ready, bus.k_is_last, bus.k_byte_num, busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t m1, m2, mr;
        int r0;
        bus.s_data = 8'd0;
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        bus.k_out_ready = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("reset_outputs");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        run_msg(str_q("Hello, world!"));
        run_msg(str_q("Hello, world"));
        run_msg(str_q("A"));

        // Hold back-pressure across the first EMIT of a five-byte message.
        m1 = str_q("ABCDE");
        push_expect(m1);
        r0 = resets_seen;
        force_bf = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send_byte(m1[i], 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("bf_hold", {bus.k_in_ready, bus.s_ready, bus.k_in}, {2'b00, 32'h41424344});
        end
        force_bf = 1'b0;
        send_byte(m1[4], 1'b1);
        wait_drain();
        release_msg();
        check("bf_msg_one_reset", resets_seen, r0 + 1);

        // Asynchronous reset in the middle of a word (pos=2).
        send_byte("x", 1'b0);
        send_byte("y", 1'b0);
        bus.s_data = "z";
        bus.s_valid = 1'b1;
        #2 reset = 1'b0;
        #1 check_reset_outputs("midop_reset_outputs");
        bus.s_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        run_msg(str_q("abc"));

        // Back-to-back messages with s_valid never dropping between them.
        m1 = str_q("Keccak!!");
        m2 = str_q("xyzzy");
        r0 = resets_seen;
        push_expect(m1);
        push_expect(m2);
        fork
            begin
                send_msg(m1);
                send_msg(m2);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int t = 0;
                    while (!in_wait && t < 500) begin
                        @(negedge clk);
                        t++;
                    end
                    repeat (3) @(posedge clk);
                    #1 bus.k_out_ready = 1'b1;
                    @(posedge clk);
                    #1 bus.k_out_ready = 1'b0;
                end
            end
        join
        wait_drain();
        check("b2b_two_resets", resets_seen, r0 + 2);
        repeat (3) @(posedge clk);
        #1;

        rand_bf = 1'b1;
        for (int n = 0; n < 10; n++) begin
            mr.delete();
            repeat ($urandom_range(1, 11)) mr.push_back(8'($urandom_range(0, 255)));
            run_msg(mr);
        end
        rand_bf = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
